fir_filter_tdm: RTL

- Parametrised, time-multiplexed N-tap signed FIR filter.
- A single multiply-accumulate unit is shared across all taps, so one output is produced every N+1 cycles.
- Coefficients are run-time loadable and the output path has rounding and saturation.
- Sits between the sample source (valid/ready) and downstream DSP logic, which consumes a one-cycle out_valid strobe.

---
 rtl/fir_pkg.sv | 23 ++
 rtl/fir_mac_unit.sv | 43 ++++
 rtl/fir_filter_tdm.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types and width helpers for the time-multiplexed FIR filter
package fir_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   // Wide enough that N full-scale products can never overflow the accumulator.
   function automatic int acc_width(input int dw, input int cw, input int n);
      return dw + cw + $clog2(n);
   endfunction

   function automatic longint sat_max(input int ow);
      return (longint'(1) <<< (ow - 1)) - 1;
   endfunction

   function automatic longint sat_min(input int ow);
      return -(longint'(1) <<< (ow - 1));
   endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// rtl/fir_mac_unit.sv - signed multiplier feeding a clearable accumulator
module fir_mac_unit #(
   parameter int DW    = 8,
   parameter int CW    = 8,
   parameter int ACC_W = 19
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    clr_i,
   input  logic                    en_i,
   input  logic signed [DW-1:0]    a_i,
   input  logic signed [CW-1:0]    b_i,
   output logic signed [ACC_W-1:0] acc_o
);

   logic signed [DW+CW-1:0]  prod;
   logic signed [ACC_W-1:0]  prod_ext;
   logic signed [ACC_W-1:0]  acc_q;
   logic signed [ACC_W-1:0]  acc_d;

   assign prod     = a_i * b_i;
   assign prod_ext = {{(ACC_W-DW-CW){prod[DW+CW-1]}}, prod};

   always_comb begin
      acc_d = acc_q;
      if (clr_i) begin
         acc_d = '0;
      end else if (en_i) begin
         acc_d = acc_q + prod_ext;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/fir_filter_tdm.sv
// rtl/fir_filter_tdm.sv - N-tap signed FIR sharing one MAC across taps, with round/saturate output
module fir_filter_tdm
   import fir_pkg::*;
#(
   parameter int N     = 8,
   parameter int DW    = 8,
   parameter int CW    = 8,
   parameter int OW    = 16,
   parameter int SHIFT = 0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic signed [DW-1:0]   x_in,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   coef_wr,
   input  logic [$clog2(N)-1:0]   coef_addr,
   input  logic signed [CW-1:0]   coef_data,
   output logic signed [OW-1:0]   y_out,
   output logic                   out_valid,
   output logic                   sat
);

   localparam int AW      = $clog2(N);
   localparam int ACC_W   = acc_width(DW, CW, N);
   localparam int CMP_W   = ((ACC_W > OW) ? ACC_W : OW) + 1;
   localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic signed [CMP_W-1:0] Y_MAX = CMP_W'(sat_max(OW));
   localparam logic signed [CMP_W-1:0] Y_MIN = CMP_W'(sat_min(OW));
   localparam logic signed [CMP_W-1:0] RND   = (SHIFT > 0) ? (CMP_W'(1) << RND_POS) : '0;

   state_t                  state_q, state_d;
   logic [AW-1:0]           k_q, k_d;
   logic signed [DW-1:0]    hist_q [N];
   logic signed [CW-1:0]    coef_q [N];
   logic signed [OW-1:0]    y_q, y_d;
   logic                    sat_q, sat_d;
   logic                    out_valid_q;
   logic                    accept, coef_we, mac_clr, mac_en, emit;
   logic signed [ACC_W-1:0] acc;
   logic signed [CMP_W-1:0] acc_ext, rounded, shifted;

   assign accept  = in_valid && in_ready;
   assign coef_we = coef_wr && (state_q == IDLE) && (int'(coef_addr) < N);

   // OUT also accepts, so back-to-back samples arrive every N+1 cycles.
   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      in_ready = 1'b0;
      mac_clr  = 1'b0;
      mac_en   = 1'b0;
      emit     = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_d = MAC;
               k_d     = '0;
               mac_clr = 1'b1;
            end
         end
         MAC: begin
            mac_en = 1'b1;
            k_d    = k_q + 1'b1;
            if (k_q == AW'(N - 1)) begin
               state_d = OUT;
            end
         end
         OUT: begin
            in_ready = 1'b1;
            emit     = 1'b1;
            state_d  = IDLE;
            if (in_valid) begin
               state_d = MAC;
               k_d     = '0;
               mac_clr = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      acc_ext = CMP_W'(acc);
      rounded = acc_ext + RND;
      shifted = rounded >>> SHIFT;
      y_d     = shifted[OW-1:0];
      sat_d   = 1'b0;
      if (shifted > Y_MAX) begin
         y_d   = Y_MAX[OW-1:0];
         sat_d = 1'b1;
      end else if (shifted < Y_MIN) begin
         y_d   = Y_MIN[OW-1:0];
         sat_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         k_q         <= '0;
         y_q         <= '0;
         sat_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         out_valid_q <= emit;
         if (emit) begin
            y_q   <= y_d;
            sat_q <= sat_d;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            hist_q[i] <= '0;
            coef_q[i] <= '0;
         end
         coef_q[0] <= CW'(1);
      end else begin
         if (accept) begin
            hist_q[0] <= x_in;
            for (int i = 1; i < N; i++) begin
               hist_q[i] <= hist_q[i-1];
            end
         end
         if (coef_we) begin
            coef_q[coef_addr] <= coef_data;
         end
      end
   end

   fir_mac_unit #(
      .DW    (DW),
      .CW    (CW),
      .ACC_W (ACC_W)
   ) u_mac (
      .clk_i (clk),
      .rst_i (reset),
      .clr_i (mac_clr),
      .en_i  (mac_en),
      .a_i   (hist_q[k_q]),
      .b_i   (coef_q[k_q]),
      .acc_o (acc)
   );

   assign y_out     = y_q;
   assign sat       = sat_q;
   assign out_valid = out_valid_q;

endmodule
